hazard_unit: RTL

- Stall/flush controller for the 5-stage MIPS pipeline.
- Covers the hazards the forwarding unit cannot: load-use, data-memory wait, taken branch/jump resolved in MEM, and halt.
- Drives enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Holds a small FSM so that multi-cycle events (memory wait, flush during an in-flight fetch, halt) stay consistent across cycles.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/hazard_unit_if.sv | 47 ++++
 rtl/hazard_stats_counter.sv | 26 ++
 rtl/hazard_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_types_pkg: shared pipeline types (hazard FSM state, reg select) |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package cpu_types_pkg;

  localparam int REGBITS = 5;

  typedef logic [REGBITS-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } hazstate_t;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_unit_if: port bundle for the hazard unit (hu / tb views)     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface hazard_unit_if #(
  parameter int REGW = 5
);
  logic            CLK;
  logic            nRST;
  logic            ihit;
  logic            dhit;
  logic [REGW-1:0] ifid_rs;
  logic [REGW-1:0] ifid_rt;
  logic            ifid_rt_used;
  logic            idex_dREN;
  logic [REGW-1:0] idex_wsel;
  logic            exm_dREN;
  logic            exm_dWEN;
  logic            exm_taken;
  logic            exm_halt;
  logic            pc_en;
  logic            ifid_en;
  logic            ifid_flush;
  logic            idex_en;
  logic            idex_flush;
  logic            exm_en;
  logic            exm_flush;
  logic            mwb_en;
  logic            halted;

  modport hu (
    input  CLK, nRST, ihit, dhit, ifid_rs, ifid_rt, ifid_rt_used, idex_dREN,
           idex_wsel, exm_dREN, exm_dWEN, exm_taken, exm_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exm_en, exm_flush,
           mwb_en, halted
  );

  modport tb (
    output CLK, nRST, ihit, dhit, ifid_rs, ifid_rt, ifid_rt_used, idex_dREN,
           idex_wsel, exm_dREN, exm_dWEN, exm_taken, exm_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exm_en, exm_flush,
           mwb_en, halted
  );

endinterface
`default_nettype wire

// File: rtl/hazard_stats_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_stats_counter: saturating event counter (HAZARD_STATS_EN)    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`ifdef HAZARD_STATS_EN
module hazard_stats_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_unit: stall/flush control for the 5-stage pipeline.          |
// | Optional statistics counters under HAZARD_STATS_EN. Revision: 1.0  |
// +--------------------------------------------------------------------+
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int REGW = 5
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNTW = 32
`endif
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            ifid_rt_used,
  input  logic            idex_dREN,
  input  logic [REGW-1:0] idex_wsel,
  input  logic            exm_dREN,
  input  logic            exm_dWEN,
  input  logic            exm_taken,
  input  logic            exm_halt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_en,
  output logic            idex_flush,
  output logic            exm_en,
  output logic            exm_flush,
  output logic            mwb_en,
  output logic            halted
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNTW-1:0] stall_cycles,
  output logic [CNTW-1:0] flush_count
`endif
);

  hazstate_t state;
  hazstate_t next_state;
  logic      memacc;
  logic      loaduse;
  logic      run_rules;
  logic      mem_ok;

  assign memacc  = exm_dREN | exm_dWEN;
  assign loaduse = idex_dREN && (idex_wsel != '0) &&
                   ((idex_wsel == ifid_rs) || (ifid_rt_used && (idex_wsel == ifid_rt)));

  always_comb begin
    pc_en      = ihit;
    ifid_en    = ihit;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exm_en     = 1'b1;
    exm_flush  = 1'b0;
    mwb_en     = 1'b1;
    halted     = 1'b0;
    next_state = state;
    run_rules  = 1'b0;
    mem_ok     = !(memacc && !dhit);

    case (state)
      RUN: run_rules = 1'b1;
      DWAIT: begin
        // The outstanding access completes: resolve the cycle as a normal RUN cycle.
        if (dhit) begin
          run_rules = 1'b1;
          mem_ok    = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exm_en, mwb_en} = '0;
        end
      end
      FLUSH: begin
        if (exm_halt || !mem_ok) begin
          run_rules = 1'b1;
        end else begin
          pc_en      = 1'b0;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          if (ihit) next_state = RUN;
        end
      end
      HALT: begin
        {pc_en, ifid_en, idex_en, exm_en, mwb_en} = '0;
        halted = 1'b1;
      end
    endcase

    if (run_rules) begin
      if (exm_halt) begin
        {pc_en, ifid_en, idex_en, exm_en, mwb_en} = '0;
        halted     = 1'b1;
        next_state = HALT;
      end else if (!mem_ok) begin
        {pc_en, ifid_en, idex_en, exm_en, mwb_en} = '0;
        next_state = DWAIT;
      end else if (exm_taken) begin
        // A missing fetch belongs to the wrong path; FLUSH discards it when it lands.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        exm_flush  = 1'b1;
        next_state = ihit ? RUN : FLUSH;
      end else if (loaduse) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        next_state = RUN;
      end else begin
        next_state = RUN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

`ifdef HAZARD_STATS_EN
  // exm_flush is raised only when a taken branch is accepted.
  hazard_stats_counter #(.W(CNTW)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (!pc_en && (state != HALT)),
    .count (stall_cycles)
  );

  hazard_stats_counter #(.W(CNTW)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (exm_flush && (state != HALT)),
    .count (flush_count)
  );
`endif

endmodule
`default_nettype wire
